// File: rtl/brick_drawer_pkg.sv
// Shared definitions for the brick drawer and the other sprite drawers.
//   - Default brick geometry and the loader's minimum draw delay.
//   - 3-bit RGB colour codes (one bit per channel).
//   - Drawer FSM state encoding and the health-to-colour map.
package brick_drawer_pkg;

  localparam int unsigned BrickW = 16;
  localparam int unsigned BrickH = 8;

  // Minimum fixed delay the level loader must wait between draw requests.
  localparam int unsigned BrickDraw = BrickW * BrickH + 2;

  localparam logic [2:0] ColBlack  = 3'b000;
  localparam logic [2:0] ColGreen  = 3'b010;
  localparam logic [2:0] ColYellow = 3'b110;
  localparam logic [2:0] ColRed    = 3'b100;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDraw = 2'd1,
    StDone = 2'd2
  } state_e;

  // Health 0 maps to black so that drawing a dead brick erases it.
  function automatic logic [2:0] health_colour(input logic [1:0] h);
    logic [2:0] c;
    unique case (h)
      2'd0:    c = ColBlack;
      2'd1:    c = ColGreen;
      2'd2:    c = ColYellow;
      default: c = ColRed;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/brick_pixel_counter.sv
// Nested row-major pixel counter for one brick rectangle.
//   clk, resetn : clock and synchronous active-low reset
//   clear       : force cx = cy = 0 (takes priority over enable)
//   enable      : advance one pixel; cx is the inner loop, cy the outer
//   cx, cy      : current pixel offset within the brick
//   last        : high while (cx, cy) addresses the bottom-right pixel
module brick_pixel_counter
  import brick_drawer_pkg::*;
#(
  parameter int unsigned BRICK_W = BrickW,
  parameter int unsigned BRICK_H = BrickH,
  parameter int unsigned CxW     = (BRICK_W > 1) ? $clog2(BRICK_W) : 1,
  parameter int unsigned CyW     = (BRICK_H > 1) ? $clog2(BRICK_H) : 1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           clear,
  input  logic           enable,
  output logic [CxW-1:0] cx,
  output logic [CyW-1:0] cy,
  output logic           last
);

  localparam logic [CxW-1:0] CxMax = CxW'(BRICK_W - 1);
  localparam logic [CyW-1:0] CyMax = CyW'(BRICK_H - 1);

  logic [CxW-1:0] cx_q, cx_d;
  logic [CyW-1:0] cy_q, cy_d;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clear) begin
      cx_d = '0;
      cy_d = '0;
    end else if (enable) begin
      if (cx_q == CxMax) begin
        cx_d = '0;
        cy_d = (cy_q == CyMax) ? '0 : cy_q + CyW'(1);
      end else begin
        cx_d = cx_q + CxW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = (cx_q == CxMax) && (cy_q == CyMax);

endmodule

// File: rtl/brick_drawer.sv
// Rasterises one BRICK_W x BRICK_H brick as one VGA plot per clock.
//   clk, resetn      : clock and synchronous active-low reset
//   start            : draw request, honoured only when idle
//   x_in, y_in       : brick top-left corner, latched on an accepted start
//   health           : brick health, latched on an accepted start; selects colour
//   x_out, y_out     : pixel coordinate (modulo 1024), zero when not plotting
//   colour           : pixel colour, zero when not plotting
//   plot             : VGA write enable, one cycle per pixel
//   busy             : high from the first pixel through the done cycle
//   done             : one-cycle pulse after the last pixel
module brick_drawer
  import brick_drawer_pkg::*;
#(
  parameter int unsigned BRICK_W = BrickW,
  parameter int unsigned BRICK_H = BrickH
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic [1:0] health,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CxW = (BRICK_W > 1) ? $clog2(BRICK_W) : 1;
  localparam int unsigned CyW = (BRICK_H > 1) ? $clog2(BRICK_H) : 1;

  state_e state_q, state_d;

  logic [9:0] x_base_q, x_base_d;
  logic [9:0] y_base_q, y_base_d;
  logic [1:0] health_q, health_d;

  logic           latch;
  logic           cnt_clear;
  logic           cnt_en;
  logic           cnt_last;
  logic [CxW-1:0] cx;
  logic [CyW-1:0] cy;

  brick_pixel_counter #(
    .BRICK_W (BRICK_W),
    .BRICK_H (BRICK_H),
    .CxW     (CxW),
    .CyW     (CyW)
  ) u_counter (
    .clk    (clk),
    .resetn (resetn),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .cx     (cx),
    .cy     (cy),
    .last   (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          latch     = 1'b1;
          cnt_clear = 1'b1;
          state_d   = StDraw;
        end
      end
      StDraw: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // A start seen here is dropped; it must still be high once back in idle.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    x_base_d = x_base_q;
    y_base_d = y_base_q;
    health_d = health_q;
    if (latch) begin
      x_base_d = x_in;
      y_base_d = y_in;
      health_d = health;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      x_base_q <= '0;
      y_base_q <= '0;
      health_q <= '0;
    end else begin
      state_q  <= state_d;
      x_base_q <= x_base_d;
      y_base_q <= y_base_d;
      health_q <= health_d;
    end
  end

  always_comb begin
    plot   = (state_q == StDraw);
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    x_out  = '0;
    y_out  = '0;
    colour = '0;
    if (plot) begin
      // Offsets are zero-extended; the 10-bit sum wraps at the screen edge.
      x_out  = x_base_q + 10'(cx);
      y_out  = y_base_q + 10'(cy);
      colour = health_colour(health_q);
    end
  end

endmodule

// File: tb/tb_brick_drawer.sv
module tb_brick_drawer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [9:0] x_in;
  logic [9:0] y_in;
  logic [1:0] health;
  logic [9:0] x_out;
  logic [9:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Results of the most recent capture run.
  int px[$];
  int py[$];
  int pc[$];
  int pcyc[$];
  int done_cyc[$];
  int busy_cnt;
  int last_busy;
  int stray;

  always #5 clk = ~clk;

  brick_drawer #(
    .BRICK_W (16),
    .BRICK_H (8)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .x_in   (x_in),
    .y_in   (y_in),
    .health (health),
    .x_out  (x_out),
    .y_out  (y_out),
    .colour (colour),
    .plot   (plot),
    .busy   (busy),
    .done   (done)
  );

  function automatic int at(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  // Issue one start, then sample every negedge for ncyc cycles. Cycle c is the
  // c-th cycle after the accepting edge (cycle 1 carries pixel 0).
  task automatic capture(input int sx, input int sy, input int sh, input int pulse_at,
                         input int reset_at, input bit hold, input int ncyc);
    px.delete(); py.delete(); pc.delete(); pcyc.delete(); done_cyc.delete();
    busy_cnt = 0; last_busy = 0; stray = 0;
    @(negedge clk);
    start = 1'b1; x_in = 10'(sx); y_in = 10'(sy); health = 2'(sh);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (plot) begin
        px.push_back(int'(x_out)); py.push_back(int'(y_out));
        pc.push_back(int'(colour)); pcyc.push_back(c);
      end else if (x_out != 0 || y_out != 0 || colour != 0) begin
        stray++;
      end
      if (done) done_cyc.push_back(c);
      if (busy) begin busy_cnt++; last_busy = c; end
      if (c == 1) begin
        start = hold; x_in = 10'd513; y_in = 10'd777; health = 2'(sh + 1);
      end
      if (c == pulse_at) begin start = 1'b1; x_in = 10'd100; end
      if (c == pulse_at + 1) start = hold;
      if (c == reset_at) resetn = 1'b0;
      if (c == reset_at + 1) resetn = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; x_in = 10'd0; y_in = 10'd0; health = 2'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({plot, busy, done, x_out, y_out, colour} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {plot, busy, done, x_out, y_out, colour});
    end
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({plot, busy, done, x_out, y_out, colour} !== 26'd0) begin
        errors++;
        $display("FAIL idle_outputs cycle %0d: got %h, expected 0", i,
                 {plot, busy, done, x_out, y_out, colour});
      end
    end
  endtask

  task automatic test_basic_draw();
    int bad;
    capture(40, 20, 3, -1, -1, 1'b0, 140);
    checks++;
    if (px.size() !== 128) begin
      errors++; $display("FAIL basic_plot_count: got %0d, expected 128", px.size());
    end
    checks++;
    if (at(pcyc, 0) !== 1 || at(pcyc, 127) !== 128) begin
      errors++;
      $display("FAIL basic_plot_window: got %0d..%0d, expected 1..128", at(pcyc, 0), at(pcyc, 127));
    end
    checks++;
    if (at(px, 0) !== 40 || at(py, 0) !== 20) begin
      errors++; $display("FAIL basic_first: got (%0d,%0d), expected (40,20)", at(px, 0), at(py, 0));
    end
    checks++;
    if (at(px, 16) !== 40 || at(py, 16) !== 21) begin
      errors++; $display("FAIL basic_pix17: got (%0d,%0d), expected (40,21)", at(px, 16), at(py, 16));
    end
    checks++;
    if (at(px, 127) !== 55 || at(py, 127) !== 27) begin
      errors++;
      $display("FAIL basic_last: got (%0d,%0d), expected (55,27)", at(px, 127), at(py, 127));
    end
    bad = 0;
    for (int i = 0; i < 128; i++)
      if (at(px, i) !== 40 + i % 16 || at(py, i) !== 20 + i / 16 || at(pc, i) !== 4) bad++;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL basic_raster: got %0d bad pixels, expected 0", bad);
    end
    checks++;
    if (done_cyc.size() !== 1 || at(done_cyc, 0) !== 129) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses first at %0d, expected 1 at 129",
               done_cyc.size(), at(done_cyc, 0));
    end
    checks++;
    if (busy_cnt !== 129 || last_busy !== 129) begin
      errors++;
      $display("FAIL basic_busy: got %0d cycles ending %0d, expected 129 ending 129",
               busy_cnt, last_busy);
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL basic_idle_zero: got %0d nonzero samples, expected 0", stray);
    end
  endtask

  task automatic test_colour_map();
    logic [2:0] exp_col [3];
    int bad;
    exp_col[0] = 3'b000; exp_col[1] = 3'b010; exp_col[2] = 3'b110;
    for (int h = 0; h < 3; h++) begin
      capture(300, 200, h, -1, -1, 1'b0, 135);
      checks++;
      if (px.size() !== 128) begin
        errors++;
        $display("FAIL colour_count h=%0d: got %0d, expected 128", h, px.size());
      end
      bad = 0;
      for (int i = 0; i < 128; i++)
        if (at(pc, i) !== int'(exp_col[h])) bad++;
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL colour_value h=%0d: got %0d (first %b), expected %b", h, bad,
                 3'(at(pc, 0)), exp_col[h]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int bad;
    capture(40, 20, 3, 50, -1, 1'b0, 140);
    checks++;
    if (px.size() !== 128 || at(px, 127) !== 55 || at(py, 127) !== 27) begin
      errors++;
      $display("FAIL ignored_start_rect: got %0d plots last (%0d,%0d), expected 128 last (55,27)",
               px.size(), at(px, 127), at(py, 127));
    end
    bad = 0;
    for (int i = 0; i < 128; i++)
      if (at(px, i) !== 40 + i % 16 || at(py, i) !== 20 + i / 16) bad++;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL ignored_start_raster: got %0d bad pixels, expected 0", bad);
    end
    checks++;
    if (done_cyc.size() !== 1) begin
      errors++; $display("FAIL ignored_start_done: got %0d pulses, expected 1", done_cyc.size());
    end
  endtask

  task automatic test_wrap();
    capture(1020, 0, 1, -1, -1, 1'b0, 135);
    checks++;
    if (at(px, 3) !== 1023 || at(px, 4) !== 0) begin
      errors++;
      $display("FAIL wrap_x: got %0d,%0d, expected 1023,0", at(px, 3), at(px, 4));
    end
    checks++;
    if (at(px, 127) !== 11 || at(py, 127) !== 7) begin
      errors++;
      $display("FAIL wrap_last: got (%0d,%0d), expected (11,7)", at(px, 127), at(py, 127));
    end
  endtask

  task automatic test_reset_mid_draw();
    capture(40, 20, 2, -1, 60, 1'b0, 80);
    checks++;
    if (px.size() !== 60 || at(pcyc, 59) !== 60) begin
      errors++;
      $display("FAIL midreset_plots: got %0d ending %0d, expected 60 ending 60",
               px.size(), at(pcyc, 59));
    end
    checks++;
    if (done_cyc.size() !== 0 || busy_cnt !== 60) begin
      errors++;
      $display("FAIL midreset_done_busy: got %0d done %0d busy, expected 0 done 60 busy",
               done_cyc.size(), busy_cnt);
    end
    capture(200, 100, 1, -1, -1, 1'b0, 140);
    checks++;
    if (px.size() !== 128 || at(px, 0) !== 200 || at(py, 0) !== 100 ||
        at(px, 127) !== 215 || at(py, 127) !== 107) begin
      errors++;
      $display("FAIL midreset_redraw: got %0d plots (%0d,%0d)..(%0d,%0d), expected 128 (200,100)..(215,107)",
               px.size(), at(px, 0), at(py, 0), at(px, 127), at(py, 127));
    end
    checks++;
    if (done_cyc.size() !== 1 || at(done_cyc, 0) !== 129) begin
      errors++;
      $display("FAIL midreset_redraw_done: got %0d at %0d, expected 1 at 129",
               done_cyc.size(), at(done_cyc, 0));
    end
  endtask

  // start held high: the DONE-cycle start is dropped, the next idle cycle accepts.
  task automatic test_back_to_back();
    capture(8, 16, 1, -1, -1, 1'b1, 259);
    checks++;
    if (px.size() !== 256) begin
      errors++; $display("FAIL b2b_count: got %0d, expected 256", px.size());
    end
    checks++;
    if (done_cyc.size() !== 2 || at(done_cyc, 0) !== 129 || at(done_cyc, 1) !== 259) begin
      errors++;
      $display("FAIL b2b_done: got %0d pulses at %0d,%0d, expected 2 at 129,259",
               done_cyc.size(), at(done_cyc, 0), at(done_cyc, 1));
    end
    checks++;
    if (at(pcyc, 128) !== 131 || at(px, 128) !== 513 || at(py, 128) !== 777 ||
        at(pc, 128) !== 6) begin
      errors++;
      $display("FAIL b2b_second: got cyc %0d (%0d,%0d) col %0d, expected cyc 131 (513,777) col 6",
               at(pcyc, 128), at(px, 128), at(py, 128), at(pc, 128));
    end
  endtask

  initial begin
    test_reset();
    test_basic_draw();
    test_colour_map();
    test_ignored_start();
    test_wrap();
    test_reset_mid_draw();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
